// File: rtl/credit_rr_if.sv
// credit_rr_if: credit/valid link bundle between NUM_REQ producers, the arbiter and downstream
`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif
interface credit_rr_if #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
);
    logic                          en;
    logic [NUM_REQ-1:0]            valid_in;
    logic [NUM_REQ*`PATH_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]            credit_out;
    logic                          credit_in;
    logic                          valid_out;
    logic [`PATH_WIDTH-1:0]        data_out;
    logic [GW-1:0]                 grant_id;
    logic [1:0]                    err;
    modport master (
        output en, valid_in, data_in, credit_in,
        input  credit_out, valid_out, data_out, grant_id, err
    );
    modport slave (
        input  en, valid_in, data_in, credit_in,
        output credit_out, valid_out, data_out, grant_id, err
    );
endinterface

// File: rtl/credit_rr_arbiter.sv
// credit_rr_arbiter: round-robin arbiter forwarding one-slot producers onto a credit-gated link
module credit_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CREDITS = 2,
    parameter int CNT_W   = 3
) (
    input logic        clk,
    input logic        rst,
    credit_rr_if.slave bus
);
    localparam int PW = `PATH_WIDTH;
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;
    state_t             r_state;
    logic [NUM_REQ-1:0] r_full, r_credit_out, w_elig, w_take;
    logic [PW-1:0]      r_slot [NUM_REQ];
    logic [PW-1:0]      r_data_out;
    logic [IW-1:0]      r_rr, r_grant_id, w_gnt, w_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_err;
    logic               r_valid_out, w_gnt_vld, w_cnt_sat;
    assign w_elig = (r_state != INIT && bus.en && r_cnt != '0) ? r_full : '0;
    // descending scan so the first eligible index at or after r_rr wins
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_rr) + k) % NUM_REQ);
            if (w_elig[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end
    assign w_take    = w_gnt_vld ? (NUM_REQ'(1) << w_gnt) : '0;
    assign w_cnt_sat = bus.credit_in && !w_gnt_vld && r_cnt == CNT_W'(CREDITS);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_full       <= '0;
            r_credit_out <= '0;
            r_valid_out  <= 1'b0;
            r_data_out   <= '0;
            r_grant_id   <= '0;
            r_rr         <= '0;
            r_cnt        <= CNT_W'(CREDITS);
            r_err        <= '0;
        end else begin
            r_state      <= bus.en ? RUN : HOLD;
            r_valid_out  <= w_gnt_vld;
            r_credit_out <= (r_state == INIT) ? '1 : w_take;
            if (w_gnt_vld) begin
                r_data_out <= r_slot[w_gnt];
                r_grant_id <= w_gnt;
                r_rr       <= (w_gnt == IW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
            end
            r_full <= (r_full & ~w_take) | bus.valid_in;
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.valid_in[i] && (!r_full[i] || w_take[i]))
                    r_slot[i] <= bus.data_in[i*PW +: PW];
            r_err <= r_err | {w_cnt_sat, |(bus.valid_in & r_full & ~w_take)};
            // a credit and a grant in the same cycle cancel out
            if (bus.credit_in != w_gnt_vld && !w_cnt_sat)
                r_cnt <= bus.credit_in ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
    end
    assign bus.valid_out  = r_valid_out;
    assign bus.data_out   = r_data_out;
    assign bus.grant_id   = r_grant_id;
    assign bus.credit_out = r_credit_out;
    assign bus.err        = r_err;
endmodule
